// File: rtl/ras_pkg.sv
// Shared types and helpers for the speculative return-address stack.
package ras_pkg;

  // Default geometry. The checkpoint struct is sized from these values, so the
  // top-level WIDTH/DEPTH parameters must match them.
  localparam int RAS_WIDTH = 31;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_NCKPT = 4;

  localparam int TOS_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // Snapshot of the stack taken at checkpoint time.
  typedef struct packed {
    logic [TOS_W-1:0]     tos;
    logic [CNT_W-1:0]     count;
    logic [RAS_WIDTH-1:0] top;
  } ras_ckpt_t;

  // Pointer increment with wrap-around at n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/ras_ckpt_ring.sv
// Checkpoint ring: in-order allocate at tail, release at head, truncate-to-tag on restore.
module ras_ckpt_ring
  import ras_pkg::*;
#(
  parameter int NCKPT = RAS_NCKPT
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     ckpt_req,
  input  logic                     ckpt_release,
  input  logic                     restore,
  input  logic [$clog2(NCKPT)-1:0] restore_tag,
  input  ras_ckpt_t                wr_data,
  output ras_ckpt_t                rd_data,
  output logic                     restore_ok,
  output logic                     ckpt_ready,
  output logic [$clog2(NCKPT)-1:0] ckpt_tag
);

  localparam int TW = $clog2(NCKPT);
  localparam int OW = $clog2(NCKPT + 1);

  logic [TW-1:0] head, tail, head_nx, tag_off;
  logic [OW-1:0] occ;
  logic          rel_ok, alloc;
  ras_ckpt_t     ck [NCKPT];

  // A tag is live when its distance from head is inside the occupied window.
  assign tag_off    = restore_tag - head;
  assign restore_ok = restore && (OW'(tag_off) < occ);
  assign ckpt_ready = occ < OW'(NCKPT);
  assign ckpt_tag   = tail;
  assign rd_data    = ck[restore_tag];
  assign rel_ok     = ckpt_release && (occ != '0);
  assign alloc      = ckpt_req && ckpt_ready && !restore_ok;
  // Restoring the head slot itself frees everything, so a same-cycle release is moot.
  assign head_nx    = (rel_ok && !(restore_ok && tag_off == '0)) ?
                      TW'(wrap_inc(int'(head), NCKPT)) : head;

  // Ring pointers and occupancy.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head_nx;
      if (restore_ok) begin
        tail <= restore_tag;
        occ  <= OW'(TW'(restore_tag - head_nx));
      end else begin
        if (alloc) tail <= TW'(wrap_inc(int'(tail), NCKPT));
        occ <= occ + OW'(alloc) - OW'(rel_ok);
      end
    end
  end

  // Snapshot storage; contents only matter while the slot is occupied.
  always_ff @(posedge clk) begin
    if (alloc) ck[tail] <= wr_data;
  end

  // A restore to a slot that is not in flight is dropped; make that visible.
  a_restore_live: assert property (@(posedge clk) disable iff (!rst_ni) restore |-> restore_ok);

endmodule

// File: rtl/ras_spec.sv
// Speculative return-address stack with checkpoint/restore.
// The branch-resolution free signal is named ckpt_release: 'release' is a reserved word.
module ras_spec
  import ras_pkg::*;
#(
  parameter int WIDTH = RAS_WIDTH,
  parameter int DEPTH = RAS_DEPTH,
  parameter int NCKPT = RAS_NCKPT
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  input  logic                     ckpt_req,
  output logic                     ckpt_ready,
  output logic [$clog2(NCKPT)-1:0] ckpt_tag,
  input  logic                     ckpt_release,
  input  logic                     restore,
  input  logic [$clog2(NCKPT)-1:0] restore_tag
);

  localparam int TW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (WIDTH != RAS_WIDTH || DEPTH != RAS_DEPTH) begin : g_cfg_check
    $error("ras_spec: WIDTH/DEPTH must match ras_pkg geometry");
  end

  logic [TW-1:0]    tos, tos_nx, tos_up, tos_dn;
  logic [CW-1:0]    count, count_nx;
  logic [WIDTH-1:0] top_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty, full, restore_ok, do_push, do_pp, do_pop;
  ras_ckpt_t        wr_ck, rd_ck;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign tos_up  = TW'(wrap_inc(int'(tos), DEPTH));
  assign tos_dn  = tos - TW'(1);
  // Push+pop on an empty stack degenerates to a plain push.
  assign do_pp   = !restore_ok && push && pop && !empty;
  assign do_push = !restore_ok && push && !do_pp;
  assign do_pop  = !restore_ok && pop && !push && !empty;

  // Post-update stack state; also the snapshot a same-cycle checkpoint captures.
  always_comb begin
    tos_nx   = tos;
    count_nx = count;
    top_nx   = mem[tos];
    if (restore_ok) begin
      tos_nx   = rd_ck.tos;
      count_nx = rd_ck.count;
      top_nx   = rd_ck.top;
    end else if (do_push) begin
      tos_nx   = tos_up;
      count_nx = full ? count : count + CW'(1);
      top_nx   = din;
    end else if (do_pp) begin
      top_nx   = din;
    end else if (do_pop) begin
      tos_nx   = tos_dn;
      count_nx = count - CW'(1);
      top_nx   = mem[tos_dn];
    end
  end

  assign wr_ck = '{tos: tos_nx, count: count_nx, top: top_nx};

  // Stack pointer and occupancy.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      tos   <= '0;
      count <= '0;
    end else begin
      tos   <= tos_nx;
      count <= count_nx;
    end
  end

  // Entry writes; a restore rewrites the checkpointed top in case it was clobbered.
  always_ff @(posedge clk) begin
    if (restore_ok || do_push || do_pp) mem[tos_nx] <= top_nx;
  end

  assign valid = !empty;
  assign dout  = valid ? mem[tos] : '0;

  ras_ckpt_ring #(.NCKPT(NCKPT)) u_ring (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .ckpt_req     (ckpt_req),
    .ckpt_release (ckpt_release),
    .restore      (restore),
    .restore_tag  (restore_tag),
    .wr_data      (wr_ck),
    .rd_data      (rd_ck),
    .restore_ok   (restore_ok),
    .ckpt_ready   (ckpt_ready),
    .ckpt_tag     (ckpt_tag)
  );

endmodule

// File: tb/tb_ras_spec.sv
// Directed scoreboard bench for ras_spec.
module tb_ras_spec;
  localparam int W = 31;
  localparam int D = 16;
  localparam int N = 4;

  logic         clk = 1'b0, rst_ni = 1'b0;
  logic         push = 1'b0, pop = 1'b0, ckpt_req = 1'b0, ckpt_release = 1'b0, restore = 1'b0;
  logic [W-1:0] din = '0;
  logic [1:0]   restore_tag = '0;
  logic [W-1:0] dout;
  logic         valid, ckpt_ready;
  logic [1:0]   ckpt_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    logic         v;
    logic [W-1:0] d;
    logic         rdy;
    logic [1:0]   ct;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ras_spec #(.WIDTH(W), .DEPTH(D), .NCKPT(N)) dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .push         (push),
    .pop          (pop),
    .din          (din),
    .dout         (dout),
    .valid        (valid),
    .ckpt_req     (ckpt_req),
    .ckpt_ready   (ckpt_ready),
    .ckpt_tag     (ckpt_tag),
    .ckpt_release (ckpt_release),
    .restore      (restore),
    .restore_tag  (restore_tag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [W-1:0] d,
                            input logic rdy, input logic [1:0] ct);
    exp_t e;
    e.tag = tag; e.v = v; e.d = d; e.rdy = rdy; e.ct = ct;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".valid"},      64'(valid),      64'(e.v));
      check({e.tag, ".dout"},       64'(dout),       64'(e.d));
      check({e.tag, ".ckpt_ready"}, 64'(ckpt_ready), 64'(e.rdy));
      check({e.tag, ".ckpt_tag"},   64'(ckpt_tag),   64'(e.ct));
    end
  endtask

  // One clock with the given inputs, then compare against the queued expectation.
  task automatic step(input logic pu, input logic po, input logic [W-1:0] d,
                      input logic cr, input logic rl, input logic rs, input logic [1:0] t);
    push = pu; pop = po; din = d; ckpt_req = cr; ckpt_release = rl;
    restore = rs; restore_tag = t;
    @(posedge clk); #1;
    push = 0; pop = 0; din = '0; ckpt_req = 0; ckpt_release = 0; restore = 0; restore_tag = '0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, during reset.
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, '0, 1, 0);
    drain();
    rst_ni = 1'b1;

    // Basic push/pop and underflow.
    expect_out("push100", 1, W'('h100), 1, 0); step(1, 0, W'('h100), 0, 0, 0, 0);
    expect_out("push200", 1, W'('h200), 1, 0); step(1, 0, W'('h200), 0, 0, 0, 0);
    expect_out("push300", 1, W'('h300), 1, 0); step(1, 0, W'('h300), 0, 0, 0, 0);
    expect_out("pop1", 1, W'('h200), 1, 0); step(0, 1, '0, 0, 0, 0, 0);
    expect_out("pop2", 1, W'('h100), 1, 0); step(0, 1, '0, 0, 0, 0, 0);
    expect_out("pop3", 0, '0, 1, 0);         step(0, 1, '0, 0, 0, 0, 0);
    expect_out("pop_empty", 0, '0, 1, 0);    step(0, 1, '0, 0, 0, 0, 0);
    check("count_after_underflow", 64'(dut.count), 64'(0));

    // Overflow: push 1..17 into 16 entries, oldest lost.
    for (int i = 1; i <= 17; i++) begin
      expect_out($sformatf("fill%0d", i), 1, W'(i), 1, 0);
      step(1, 0, W'(i), 0, 0, 0, 0);
    end
    check("count_saturated", 64'(dut.count), 64'(16));
    for (int j = 1; j <= 16; j++) begin
      if (j < 16) expect_out($sformatf("drain%0d", j), 1, W'(17 - j), 1, 0);
      else        expect_out("drain16", 0, '0, 1, 0);
      step(0, 1, '0, 0, 0, 0, 0);
    end

    // Checkpoint then restore repairs an overwritten top.
    expect_out("pushA", 1, W'('hA), 1, 0); step(1, 0, W'('hA), 0, 0, 0, 0);
    check("ckpt_tag_same_cycle", 64'(ckpt_tag), 64'(0));
    expect_out("ckpt0", 1, W'('hA), 1, 1); step(0, 0, '0, 1, 0, 0, 0);
    expect_out("popA", 0, '0, 1, 1);        step(0, 1, '0, 0, 0, 0, 0);
    expect_out("pushB", 1, W'('hB), 1, 1);  step(1, 0, W'('hB), 0, 0, 0, 0);
    expect_out("restore0", 1, W'('hA), 1, 0); step(0, 0, '0, 0, 0, 1, 0);

    // Fill the ring; a request while full is dropped even with a release.
    expect_out("fill_ck0", 1, W'('hA), 1, 1); step(0, 0, '0, 1, 0, 0, 0);
    expect_out("fill_ck1", 1, W'('hA), 1, 2); step(0, 0, '0, 1, 0, 0, 0);
    expect_out("fill_ck2", 1, W'('hA), 1, 3); step(0, 0, '0, 1, 0, 0, 0);
    expect_out("fill_ck3", 1, W'('hA), 0, 0); step(0, 0, '0, 1, 0, 0, 0);
    check("ready_full", 64'(ckpt_ready), 64'(0));
    expect_out("req_rel_full", 1, W'('hA), 1, 0); step(0, 0, '0, 1, 1, 0, 0);
    check("occ_after_drop", 64'(dut.u_ring.occ), 64'(3));
    check("head_after_drop", 64'(dut.u_ring.head), 64'(1));
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("rel%0d", k), 1, W'('hA), 1, 0);
      step(0, 0, '0, 0, 1, 0, 0);
    end
    check("occ_empty", 64'(dut.u_ring.occ), 64'(0));

    // Restore to tag 1 combined with release of head 0.
    expect_out("ck_s0", 1, W'('h11), 1, 1); step(1, 0, W'('h11), 1, 0, 0, 0);
    expect_out("ck_s1", 1, W'('h22), 1, 2); step(1, 0, W'('h22), 1, 0, 0, 0);
    expect_out("ck_s2", 1, W'('h33), 1, 3); step(1, 0, W'('h33), 1, 0, 0, 0);
    expect_out("restore1_rel", 1, W'('h22), 1, 1); step(0, 0, '0, 0, 1, 1, 1);
    check("rr_head", 64'(dut.u_ring.head), 64'(1));
    check("rr_tail", 64'(dut.u_ring.tail), 64'(1));
    check("rr_occ",  64'(dut.u_ring.occ),  64'(0));
    check("rr_count", 64'(dut.count), 64'(3));

    // Push+pop replaces top; push during restore is ignored.
    expect_out("pop_to2", 1, W'('h11), 1, 1); step(0, 1, '0, 0, 0, 0, 0);
    expect_out("pushpop55", 1, W'('h55), 1, 1); step(1, 1, W'('h55), 0, 0, 0, 0);
    check("pp_count", 64'(dut.count), 64'(2));
    expect_out("ck55", 1, W'('h55), 1, 2); step(0, 0, '0, 1, 0, 0, 0);
    expect_out("push66", 1, W'('h66), 1, 2); step(1, 0, W'('h66), 0, 0, 0, 0);
    expect_out("restore_push", 1, W'('h55), 1, 1); step(1, 0, W'('h77), 1, 0, 1, 1);
    check("rp_count", 64'(dut.count), 64'(2));
    check("rp_occ", 64'(dut.u_ring.occ), 64'(0));

    // Reset mid-operation clears everything.
    rst_ni = 1'b0;
    #1;
    expect_out("midreset", 0, '0, 1, 0);
    drain();
    check("midreset_count", 64'(dut.count), 64'(0));
    @(posedge clk); #1;
    rst_ni = 1'b1;
    expect_out("post_reset", 0, '0, 1, 0); step(0, 0, '0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_spec.md
# ras_spec

Speculative return-address stack with in-order checkpoint/restore, the parametrised successor to the single-level flush RAS in the branch predictor front end. Calls push and returns pop a circular stack of `WIDTH`-bit addresses. Each predicted branch can take a checkpoint of the stack state. A misprediction restores the stack to any in-flight checkpoint, and all younger checkpoints are discarded in the same cycle. Sits beside the BTB; fed by decode-time call/return hints and by the branch-resolution unit.

## Interface
- `WIDTH`, 31: return-address width.
- `DEPTH`, 16: stack entries; power of two, ≥ 2.
- `NCKPT`, 4: checkpoint slots; power of two, ≥ 2.
- `clk` in 1: clock; the block uses this single clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `push` in 1: call; push `din`.
- `pop` in 1: return; pop top.
- `din` in `WIDTH`: return address to push.
- `dout` out `WIDTH`: current top of stack; 0 when `valid`=0.
- `valid` out 1: stack non-empty (count ≠ 0).
- `ckpt_req` in 1: allocate a checkpoint this cycle.
- `ckpt_ready` out 1: a checkpoint slot is free.
- `ckpt_tag` out `$clog2(NCKPT)`: tag that a request this cycle receives (ring tail).
- `release` in 1: oldest checkpoint resolved correct; free it.
- `restore` in 1: misprediction; roll back to `restore_tag`.
- `restore_tag` in `$clog2(NCKPT)`: checkpoint to restore.

## Operation
- State:
  - `tos` (`$clog2(DEPTH)`), `count` (0..`DEPTH`), storage array `mem[DEPTH]` (not reset).
  - Checkpoint ring `ck[NCKPT]` of {tos, count, top}, with `head`, `tail` and `occ` (0..`NCKPT`).
- Stack update, with no restore in the cycle:
  - `push` only: `tos`+1 (wraps); `mem[tos+1]`=`din`; `count` saturates at `DEPTH`. At full, the oldest entry is silently overwritten.
  - `pop` only: if `count`>0, `tos`−1 (wraps) and `count`−1. If `count`=0, the pop is ignored.
  - `push`&`pop`: `mem[tos]`=`din`, `tos` and `count` unchanged. If `count`=0, it behaves as `push` only.
- Checkpoint: if `ckpt_req` && `ckpt_ready` && !`restore`:
  - `ck[tail]` = post-update {tos, count, mem value at post-update tos}, i.e. including this cycle's push/pop.
  - `tail`+1; `occ`+1.
  - `ckpt_req` while !`ckpt_ready` is dropped. The requester must check `ckpt_ready`.
- Release: if `release` && `occ`>0: `head`+1, `occ`−1. A release at `occ`=0 is ignored.
- Restore to tag T. This is legal only if T is occupied; an unoccupied T is ignored and flagged by an assertion.
  - `tos`, `count` come from `ck[T]`; `mem[ck[T].tos]`=`ck[T].top`, which repairs a top overwritten after the checkpoint.
  - `tail`=T, and `occ` is recomputed as (T−`head`) mod `NCKPT`. T and all younger checkpoints are freed.
  - `push`, `pop`, `ckpt_req` in the same cycle are ignored.
- Restore + release in the same cycle:
  - If T≠`head`: the release applies first (`head`+1), and `occ` is recomputed against the new head.
  - If T=`head`: the release is ignored and `occ` becomes 0.
- `ckpt_ready` = `occ`<`NCKPT`, computed from registered state only. A same-cycle release does not enable allocation.

## Timing
- All state registers update on `clk` rising edge. `dout`/`valid` are combinational from registered `tos`/`count`.
- Push, pop and restore effects are visible on `dout` the next cycle. There is no same-cycle bypass.
- `ckpt_tag` is valid in the same cycle as `ckpt_req`.
- Reset (`rst_ni`=0, async): `tos`=0, `count`=0, `head`=`tail`=0, `occ`=0.
  - Outputs during and after reset: `valid`=0, `dout`=0, `ckpt_ready`=1, `ckpt_tag`=0.
  - A reset mid-operation discards all stack and checkpoint state. `mem` contents are don't-care.

## Structure
- `ras_pkg`: `ras_ckpt_t` struct {tos, count, top} parametrised through package localparams or a typedef macro; and a helper function for the wrap-around pointer increment.
- One sub-module, `ras_ckpt_ring`: the ring storage plus `head`/`tail`/`occ` logic, alloc/release/truncate-to-tag. The stack array and the update logic stay in `ras_spec`.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 -> `dout`=0x300, `valid`=1. Three pops -> `valid`=0, `dout`=0. A fourth pop -> no change.
- `DEPTH`=16: push 1..17 -> `count`=16, `dout`=17. 16 pops return 17..2, then `valid`=0.
- Push 0xA, ckpt (tag 0), pop, push 0xB -> `dout`=0xB. Restore 0 -> `dout`=0xA, `valid`=1, `ckpt_ready`=1, `ckpt_tag`=0.
- Four ckpts -> `ckpt_ready`=0. A fifth `ckpt_req`+`release` -> the request is dropped; next cycle `ckpt_ready`=1, `ckpt_tag`=0.
- Ckpts tags 0,1,2, then restore 1 with release in the same cycle -> `head`=1, `tail`=1, `occ`=0, with the stack state of checkpoint 1.
- Push+pop together with 0x55 at `count`=2 -> `dout`=0x55, `count`=2. Push during restore -> ignored.
